// File: rtl/imem_loader_pkg.sv
// Shared constants and the loader state type for the instruction-memory loader.
package imem_pkg;

  localparam int IMEM_DEPTH = 32;
  localparam int IMEM_AW    = 5;

  localparam bit BYTE_BIG    = 1'b1;
  localparam bit BYTE_LITTLE = 1'b0;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
interface imem_loader_if import imem_pkg::*; #(
  parameter int AW = IMEM_AW
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_pc;
  logic [31:0]   wr_data;

  // loader side
  modport slave (
    input  in_valid, in_data,
    output in_ready, wr_en, wr_addr, wr_pc, wr_data
  );

  // byte source / memory side
  modport master (
    output in_valid, in_data,
    input  in_ready, wr_en, wr_addr, wr_pc, wr_data
  );
endinterface

// File: rtl/imem_loader_byte_packer.sv
// Assembles four 8-bit beats into one 32-bit word with selectable byte order.
// word/word_valid are combinational so the 4th beat's word is usable at the
// same edge that accepts it.
module byte_packer import imem_pkg::*; #(
  parameter bit BIG_ENDIAN = BYTE_BIG
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        beat_valid,
  input  logic [7:0]  beat_data,
  output logic [31:0] word,
  output logic        word_valid
);
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q, word_d;
  logic [31:0] merged;
  logic [1:0]  lane;

  // place the incoming beat into its byte lane and advance the beat counter
  always_comb begin
    lane   = BIG_ENDIAN ? ~cnt_q : cnt_q;
    merged = word_q;
    merged[{lane, 3'b000} +: 8] = beat_data;
    word_d = beat_valid ? merged : word_q;
    cnt_d  = cnt_q;
    if (clear)           cnt_d = 2'd0;
    else if (beat_valid) cnt_d = cnt_q + 2'd1;
  end

  // beat counter and partial word storage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= 2'd0;
      word_q <= 32'd0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word       = merged;
  assign word_valid = beat_valid && (cnt_q == 2'd3);
endmodule

// File: rtl/imem_loader.sv
// Loads a byte stream into instruction memory, one registered write per word.
module imem_loader import imem_pkg::*; #(
  parameter int DEPTH      = IMEM_DEPTH,
  parameter int AW         = IMEM_AW,
  parameter bit BIG_ENDIAN = BYTE_BIG
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW:0]   len,
  input  logic          abort,
  imem_loader_if.slave  bus,
  output logic          busy,
  output logic          done,
  output logic          error,
  output logic [7:0]    checksum
);
  loader_state_e state_q, state_d;
  logic          in_ready_q, in_ready_d;
  logic          wr_en_q, wr_en_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]   wr_data_q, wr_data_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          error_q, error_d;
  logic [7:0]    checksum_q, checksum_d;
  logic [AW:0]   len_q, len_d;
  logic [AW-1:0] word_cnt_q, word_cnt_d;

  logic          fire;
  logic          len_ok;
  logic          pk_clear;
  logic [31:0]   pk_word;
  logic          pk_word_valid;

  // abort wins over a byte offered in the same cycle, so that byte is not consumed
  assign fire     = bus.in_valid && in_ready_q && !abort;
  assign len_ok   = (len != '0) && (len <= (AW+1)'(DEPTH));
  assign pk_clear = (state_q != S_LOAD) || abort;

  byte_packer #(.BIG_ENDIAN(BIG_ENDIAN)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (pk_clear),
    .beat_valid (fire),
    .beat_data  (bus.in_data),
    .word       (pk_word),
    .word_valid (pk_word_valid)
  );

  // next-state and next-output computation for the load sequence
  always_comb begin
    state_d    = state_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    error_d    = 1'b0;
    checksum_d = checksum_q;
    len_d      = len_q;
    word_cnt_d = word_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (len_ok) begin
            state_d    = S_LOAD;
            len_d      = len;
            word_cnt_d = '0;
            checksum_d = 8'd0;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_LOAD: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (fire) begin
          checksum_d = checksum_q + bus.in_data;
          if (pk_word_valid) begin
            state_d   = S_WRITE;
            wr_addr_d = word_cnt_q;
            wr_data_d = pk_word;
          end
        end
      end
      S_WRITE: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if ({1'b0, word_cnt_q} == len_q - (AW+1)'(1)) begin
          state_d = S_DONE;
        end else begin
          word_cnt_d = word_cnt_q + AW'(1);
          state_d    = S_LOAD;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    in_ready_d = (state_d == S_LOAD);
    wr_en_d    = (state_d == S_WRITE);
    busy_d     = (state_d == S_LOAD) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      in_ready_q <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 32'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      checksum_q <= 8'd0;
      len_q      <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      error_q    <= error_d;
      checksum_q <= checksum_d;
      len_q      <= len_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  assign bus.in_ready = in_ready_q;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_pc    = 8'({wr_addr_q, 2'b00});
  assign bus.wr_data  = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign checksum     = checksum_q;
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a big-endian and a little-endian instance share one
// random byte stream; writes are compared against words built from the bytes.
module tb_imem_loader;
  import imem_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [5:0] len = '0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = '0;

  logic       busy_be, done_be, error_be, busy_le, done_le, error_le;
  logic [7:0] ck_be, ck_le;

  imem_loader_if bus_be ();
  imem_loader_if bus_le ();

  assign bus_be.in_valid = in_valid;
  assign bus_be.in_data  = in_data;
  assign bus_le.in_valid = in_valid;
  assign bus_le.in_data  = in_data;

  imem_loader #(.BIG_ENDIAN(BYTE_BIG)) dut_be (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .bus(bus_be), .busy(busy_be), .done(done_be), .error(error_be), .checksum(ck_be)
  );
  imem_loader #(.BIG_ENDIAN(BYTE_LITTLE)) dut_le (
    .clk(clk), .rst_n(rst_n), .start(start), .len(len), .abort(abort),
    .bus(bus_le), .busy(busy_le), .done(done_le), .error(error_le), .checksum(ck_le)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // write/pulse monitor
  int          cyc = 0;
  logic [4:0]  wa_q[$];
  logic [7:0]  wp_q[$];
  logic [31:0] wd_be_q[$];
  logic [31:0] wd_le_q[$];
  int          done_cnt, err_cnt, done_cyc, last_wr_cyc;
  bit          busy_seen, rdy_seen;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bus_be.wr_en) begin
      wa_q.push_back(bus_be.wr_addr);
      wp_q.push_back(bus_be.wr_pc);
      wd_be_q.push_back(bus_be.wr_data);
      last_wr_cyc = cyc;
    end
    if (bus_le.wr_en) wd_le_q.push_back(bus_le.wr_data);
    if (done_be) begin done_cnt++; done_cyc = cyc; end
    if (error_be) err_cnt++;
    if (busy_be) busy_seen = 1;
    if (bus_be.in_ready) rdy_seen = 1;
  end

  task automatic clear_mon();
    wa_q.delete(); wp_q.delete(); wd_be_q.delete(); wd_le_q.delete();
    done_cnt = 0; err_cnt = 0; done_cyc = -1; last_wr_cyc = -1;
    busy_seen = 0; rdy_seen = 0;
  endtask

  // reference model: byte list -> words (first byte most significant) and checksum
  logic [7:0]  stim_q[$];
  logic [31:0] exp_q[$];
  logic [7:0]  exp_ck;

  task automatic build_model(input int nbytes);
    exp_q.delete();
    exp_ck = 8'd0;
    for (int i = 0; i < nbytes; i++) exp_ck = exp_ck + stim_q[i];
    for (int w = 0; w < nbytes / 4; w++)
      exp_q.push_back({stim_q[4*w], stim_q[4*w+1], stim_q[4*w+2], stim_q[4*w+3]});
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  task automatic do_start(input int l);
    @(negedge clk); start = 1'b1; len = 6'(l);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int n = 0;
    int g = gaps ? $urandom_range(0, 2) : 0;
    repeat (g) begin @(negedge clk); in_valid = 1'b0; end
    @(negedge clk); in_valid = 1'b1; in_data = b;
    while (!bus_be.in_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) chk("ready_timeout", 40'd0, 40'd1);
  endtask

  task automatic send_bytes(input int from, input int to, input bit gaps);
    for (int i = from; i < to; i++) send_byte(stim_q[i], gaps);
    @(negedge clk); in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy_be || done_be) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) chk("idle_timeout", 40'd1, 40'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_load(input string tag, input int nexp, input bit exp_done);
    int m;
    chk({tag, "_nwr"}, 40'(wa_q.size()), 40'(nexp));
    chk({tag, "_nwr_le"}, 40'(wd_le_q.size()), 40'(nexp));
    m = (wa_q.size() < nexp) ? wa_q.size() : nexp;
    if (wd_le_q.size() < m) m = wd_le_q.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_addr"}, 40'(wa_q[i]), 40'(i));
      chk({tag, "_pc"}, 40'(wp_q[i]), 40'(i * 4));
      chk({tag, "_data_be"}, 40'(wd_be_q[i]), 40'(exp_q[i]));
      chk({tag, "_data_le"}, 40'(wd_le_q[i]), 40'(bswap(exp_q[i])));
    end
    chk({tag, "_done_cnt"}, 40'(done_cnt), 40'(exp_done ? 1 : 0));
    if (exp_done) chk({tag, "_done_lat"}, 40'(done_cyc), 40'(last_wr_cyc + 1));
    chk({tag, "_cksum_be"}, 40'(ck_be), 40'(exp_ck));
    chk({tag, "_cksum_le"}, 40'(ck_le), 40'(exp_ck));
    chk({tag, "_busy"}, 40'(busy_be), 40'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 40'(busy_be), 40'd0);
    chk({tag, "_done"}, 40'(done_be), 40'd0);
    chk({tag, "_error"}, 40'(error_be), 40'd0);
    chk({tag, "_in_ready"}, 40'(bus_be.in_ready), 40'd0);
    chk({tag, "_wr_en"}, 40'(bus_be.wr_en), 40'd0);
    chk({tag, "_wr_addr"}, 40'(bus_be.wr_addr), 40'd0);
    chk({tag, "_wr_data"}, 40'(bus_be.wr_data), 40'd0);
    chk({tag, "_cksum"}, 40'(ck_be), 40'd0);
    chk({tag, "_wr_data_le"}, 40'(bus_le.wr_data), 40'd0);
  endtask

  task automatic rand_bytes(input int n);
    stim_q.delete();
    for (int i = 0; i < n; i++) stim_q.push_back(8'($urandom_range(0, 255)));
  endtask

  initial begin
    int nw, nwr_before;
    clear_mon();
    #12;
    check_zero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single word, big-endian layout
    clear_mon();
    stim_q = '{8'h01, 8'h4B, 8'h48, 8'h20};
    build_model(4);
    do_start(1); send_bytes(0, 4, 0); wait_idle();
    check_load("single", 1, 1);
    chk("single_lit_data", 40'(exp_q[0]), 40'h014B4820);
    chk("single_lit_cksum", 40'(ck_be), 40'hB4);

    // little-endian byte order
    clear_mon();
    stim_q = '{8'h20, 8'h48, 8'h4B, 8'h01};
    build_model(4);
    do_start(1); send_bytes(0, 4, 0); wait_idle();
    check_load("endian", 1, 1);
    chk("endian_le_lit", 40'(wd_le_q.size() > 0 ? wd_le_q[0] : 32'hDEAD), 40'h014B4820);

    // illegal lengths leave checksum alone
    clear_mon();
    do_start(0); repeat (3) @(negedge clk);
    do_start(33); repeat (3) @(negedge clk);
    do_start(63); repeat (3) @(negedge clk);
    chk("illegal_err_cnt", 40'(err_cnt), 40'd3);
    chk("illegal_busy", 40'(busy_seen), 40'd0);
    chk("illegal_ready", 40'(rdy_seen), 40'd0);
    chk("illegal_nwr", 40'(wa_q.size()), 40'd0);
    chk("illegal_cksum", 40'(ck_be), 40'(exp_ck));

    // full memory with random valid gaps
    clear_mon();
    stim_q.delete();
    for (int n = 0; n < 32; n++) begin
      logic [31:0] w;
      w = 32'h20080000 + 32'(n);
      stim_q.push_back(w[31:24]); stim_q.push_back(w[23:16]);
      stim_q.push_back(w[15:8]);  stim_q.push_back(w[7:0]);
    end
    build_model(128);
    do_start(32); send_bytes(0, 128, 1); wait_idle();
    check_load("full", 32, 1);
    chk("full_last_pc", 40'(wp_q.size() > 0 ? wp_q[wp_q.size()-1] : 8'hFF), 40'h7C);

    // random loads
    for (int r = 0; r < 5; r++) begin
      clear_mon();
      nw = $urandom_range(1, 6);
      rand_bytes(4 * nw);
      build_model(4 * nw);
      do_start(nw); send_bytes(0, 4 * nw, 1); wait_idle();
      check_load("rand", nw, 1);
    end

    // abort two bytes into word 3, then restart from address 0
    clear_mon();
    rand_bytes(14);
    build_model(14);
    do_start(5); send_bytes(0, 14, 1);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    wait_idle();
    check_load("abort", 3, 0);
    clear_mon();
    rand_bytes(4);
    build_model(4);
    do_start(1); send_bytes(0, 4, 0); wait_idle();
    check_load("after_abort", 1, 1);

    // start while loading is ignored; len stays at 2
    clear_mon();
    rand_bytes(8);
    build_model(8);
    do_start(2); send_bytes(0, 2, 0);
    start = 1'b1; len = 6'd7; @(negedge clk); start = 1'b0;
    send_bytes(2, 8, 1); wait_idle();
    check_load("busy_start", 2, 1);

    // start together with abort in LOAD: abort only
    clear_mon();
    rand_bytes(1);
    do_start(3); send_bytes(0, 1, 0);
    start = 1'b1; abort = 1'b1; len = 6'd1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("start_abort_busy", 40'(busy_be), 40'd0);
    chk("start_abort_nwr", 40'(wa_q.size()), 40'd0);
    chk("start_abort_done", 40'(done_cnt), 40'd0);

    // asynchronous reset mid-load
    clear_mon();
    rand_bytes(8);
    do_start(2); send_bytes(0, 5, 0);
    nwr_before = wa_q.size();
    chk("prereset_busy", 40'(busy_be), 40'd1);
    @(posedge clk); #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_nwr", 40'(wa_q.size()), 40'(nwr_before));
    chk("post_rst_busy", 40'(busy_be), 40'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Program loader that writes 32-bit MIPS instructions into the instruction memory before the core runs. It accepts a byte stream over a valid/ready handshake and assembles every four bytes into one instruction word. Each completed word goes out as a single-cycle write at an incrementing word address. It drives the write port of the instruction store; the core's fetch path reads that store by byte PC.

Parameters:
DEPTH, 32, number of 32-bit instruction words in the target memory
AW, 5, word-address width, equal to clog2(DEPTH)
BIG_ENDIAN, 1, 1: first byte received lands in [31:24]; 0: first byte lands in [7:0]

Ports:
clk  in  1  clock; all logic is on the rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request to begin a load; sampled only in IDLE
len  in  AW+1  number of words to load, sampled with start; legal range 1..DEPTH
abort  in  1  cancels a load in progress
in_valid  in  1  byte-stream valid
in_data  in  8  byte-stream data
in_ready  out  1  loader can accept a byte
wr_en  out  1  instruction-memory write strobe, one cycle per word
wr_addr  out  AW  word address
wr_pc  out  8  byte address of the word, equal to {wr_addr,2'b00} zero-extended; matches the fetch PC
wr_data  out  32  assembled instruction
busy  out  1  high in LOAD and WRITE
done  out  1  one-cycle pulse after the last word is written
error  out  1  one-cycle pulse when start is given with an illegal len
checksum  out  8  mod-256 sum of all bytes accepted in the current/last load

Behaviour:
- Reset (asynchronous, active-low): state goes to IDLE. in_ready, wr_en, busy, done and error are 0. wr_addr, wr_data and checksum are 0. The byte counter and word counter are 0.
- Reset mid-load: the load stops immediately and no further writes occur. Words already written stay in memory; the memory is not owned by this block.
- States: IDLE, LOAD, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start with 1<=len<=DEPTH: go to LOAD. Latch len, clear byte_cnt, word_cnt and checksum.
  - start with len==0 or len>DEPTH: error=1 for the next cycle, stay in IDLE, leave checksum unchanged.
- LOAD:
  - in_ready=1.
  - A byte transfers when in_valid&&in_ready at a rising edge. On transfer: byte_cnt increments (2-bit, wraps), checksum += in_data (8-bit wrap), and the byte is placed per BIG_ENDIAN.
  - BIG_ENDIAN=1: byte 0 goes to [31:24], byte 3 to [7:0]. BIG_ENDIAN=0: byte 0 goes to [7:0].
  - The 4th byte transfer moves the FSM to WRITE.
  - Gaps in in_valid are allowed and cause no timeout.
- WRITE:
  - Lasts exactly one cycle. wr_en=1, wr_addr=word_cnt, wr_data=assembled word, in_ready=0.
  - If word_cnt==len-1, go to DONE. Otherwise word_cnt++ and return to LOAD.
- DONE: done=1 for one cycle, then go to IDLE. checksum holds its value until the next legal start.
- Latency: the 4th byte is accepted at edge k; wr_en is high in the cycle after edge k. Peak throughput is one word per 5 cycles.
- wr_addr/wr_pc/wr_data are registered and hold their last value when wr_en=0. Consumers qualify them with wr_en only.
- abort:
  - In LOAD: go to IDLE next edge. A partial word is discarded and not written. No done pulse.
  - In WRITE: the write in the current cycle still completes, then go to IDLE with no done pulse.
  - In IDLE or DONE: no effect.
- start outside IDLE is ignored, including when start and abort are asserted together.
- Address range: with len==DEPTH the last write goes to address DEPTH-1 (31 → wr_pc 0x7C). The address never wraps.

Decomposition:
- Shared package (imem_pkg): IMEM_DEPTH=32, IMEM_AW=5, the loader state enum (IDLE/LOAD/WRITE/DONE) and the BYTE_BIG/BYTE_LITTLE constants.
- One natural sub-module: byte_packer. It takes 8-bit beats and produces a 32-bit word with the endianness handling, a 2-bit counter and a word_valid pulse. The FSM, address counter and checksum stay in imem_loader.

Test Plan:
- Single word, big-endian: start, len=1, bytes 01 4B 48 20 → one wr_en with wr_addr=0, wr_pc=0x00, wr_data=0x014B4820; checksum=0xB4; done pulse one cycle later; no extra wr_en.
- Illegal length: start with len=0, then start with len=33 → error pulses once for each; busy stays 0; in_ready stays 0; no wr_en.
- Full memory: len=32, word n = 0x20080000+n, with random in_valid gaps → 32 writes at addresses 0..31 in order; last wr_pc=0x7C; done after the write to address 31.
- Abort: abort after 2 bytes of word 3 → words 0..2 written; no write to address 3; no done; a new start begins again at address 0.
- Endianness: BIG_ENDIAN=0, bytes 20 48 4B 01 → wr_data=0x014B4820.
- Reset and busy start: rst_n pulsed low mid-LOAD → outputs return to 0 asynchronously and no further wr_en occurs. start asserted during LOAD → ignored; len stays unchanged.
